// File: rtl/ingress_dispatch_pkg.sv
// Shared definitions for the ingress dispatch slice: word layout, header codes
// and the metadata-length to expected-word-count helper.
package ingress_dispatch_pkg;

    localparam int WORD_W      = 134;
    localparam int HDR_HI      = 133;
    localparam int HDR_LO      = 132;
    localparam int LEN_HI      = 123;
    localparam int LEN_LO      = 113;
    localparam int LEN_W       = 11;
    localparam int BLOCK_WORDS = 4;
    localparam int META_WORDS  = 2;

    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_MID  = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_META1 = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    // Metadata words plus the 64-byte blocks the length occupies (rounded up).
    function automatic logic [7:0] expected_words(input logic [LEN_W-1:0] len);
        logic [5:0] blocks;
        blocks = {1'b0, len[10:6]} + {5'd0, (len[5:0] != 6'd0)};
        return 8'(META_WORDS) + 8'(BLOCK_WORDS) * {2'b00, blocks};
    endfunction

endpackage

// File: rtl/ingress_dispatch_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always presented on o_q,
// prefetched from the array into a register with a same-cycle write bypass.
module sync_showahead_fifo #(
    parameter int DW = 1,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr,
    input  logic [DW-1:0] i_data,
    input  logic          i_rd,
    output logic [DW-1:0] o_q,
    output logic [AW:0]   o_usedw
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_q;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] w_rd_ptr_next;
    logic [AW:0]   r_count;
    logic          w_wr_en;
    logic          w_rd_en;

    // Count is bounded by 2^AW, so its MSB alone flags full.
    assign w_wr_en       = i_wr && !r_count[AW];
    assign w_rd_en       = i_rd && (r_count != '0);
    assign w_rd_ptr_next = w_rd_en ? r_rd_ptr + {{(AW-1){1'b0}}, 1'b1} : r_rd_ptr;
    assign o_q           = r_q;
    assign o_usedw       = r_count;

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= i_data;
        if (w_wr_en && (r_wr_ptr == w_rd_ptr_next))
            r_q <= i_data;
        else
            r_q <= r_mem[w_rd_ptr_next];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_next;
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ingress_dispatch.sv
// Buffers complete packets and hands them whole, round-robin, to two engines,
// checking each packet's word count against its metadata length.
module ingress_dispatch
    import ingress_dispatch_pkg::*;
#(
    parameter int PKT_AW   = 8,
    parameter int VAL_AW   = 6,
    parameter int AF_LEVEL = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_pkt_wr,
    input  logic [WORD_W-1:0] in_pkt,
    input  logic              in_valid_wr,
    input  logic              in_valid,
    output logic              in_pkt_almostfull,
    output logic              out_pkt_wr_0,
    output logic [WORD_W-1:0] out_pkt_0,
    output logic              out_valid_wr_0,
    output logic              out_valid_0,
    input  logic              in_almostfull_0,
    output logic              out_pkt_wr_1,
    output logic [WORD_W-1:0] out_pkt_1,
    output logic              out_valid_wr_1,
    output logic              out_valid_1,
    input  logic              in_almostfull_1,
    output logic [15:0]       err_cnt
);

    localparam logic [PKT_AW:0] AF_THR = AF_LEVEL[PKT_AW:0];

    logic [WORD_W-1:0] w_pkt_q;
    logic [PKT_AW:0]   w_pkt_usedw;
    logic              w_val_q;
    logic [VAL_AW:0]   w_val_usedw;
    logic              w_pkt_rd;
    logic              w_val_rd;

    state_t      r_state, w_state_next;
    logic        r_sel, r_rr_ptr;
    logic [7:0]  r_exp, r_cnt;
    logic [15:0] r_err_cnt;
    logic [1:0]  w_af;
    logic        w_can_start, w_pick;
    logic        w_word, w_tail, w_match, w_valid_bit;
    logic [7:0]  w_cnt_now, w_exp_now;
    logic [1:0]  w_pkt_wr_next, w_valid_wr_next;

    sync_showahead_fifo #(.DW(WORD_W), .AW(PKT_AW)) u_pkt_fifo (
        .clk(clk), .reset(reset),
        .i_wr(in_pkt_wr), .i_data(in_pkt), .i_rd(w_pkt_rd),
        .o_q(w_pkt_q), .o_usedw(w_pkt_usedw)
    );

    sync_showahead_fifo #(.DW(1), .AW(VAL_AW)) u_val_fifo (
        .clk(clk), .reset(reset),
        .i_wr(in_valid_wr), .i_data(in_valid), .i_rd(w_val_rd),
        .o_q(w_val_q), .o_usedw(w_val_usedw)
    );

    assign in_pkt_almostfull = (w_pkt_usedw >= AF_THR);
    assign w_af              = {in_almostfull_1, in_almostfull_0};

    // A buffered flag means a whole packet is present; prefer rr_ptr, else the other.
    always_comb begin
        w_can_start = 1'b0;
        w_pick      = r_rr_ptr;
        if (w_val_usedw != '0) begin
            if (!w_af[r_rr_ptr]) begin
                w_can_start = 1'b1;
            end else if (!w_af[~r_rr_ptr]) begin
                w_can_start = 1'b1;
                w_pick      = ~r_rr_ptr;
            end
        end
    end

    assign w_word      = (r_state != ST_IDLE) && (w_pkt_usedw != '0);
    assign w_tail      = w_word && (w_pkt_q[HDR_HI:HDR_LO] == HDR_TAIL);
    assign w_exp_now   = (r_state == ST_META1) ? expected_words(w_pkt_q[LEN_HI:LEN_LO]) : r_exp;
    assign w_cnt_now   = (r_state == ST_META1) ? 8'd1 : r_cnt + 8'd1;
    assign w_match     = (w_cnt_now == w_exp_now);
    assign w_valid_bit = w_val_q & w_match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_can_start) w_state_next = ST_META1;
            ST_META1: if (w_word) w_state_next = w_tail ? ST_IDLE : ST_SEND;
            ST_SEND:  if (w_tail) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pkt_rd        = w_word;
        w_val_rd        = w_tail;
        w_pkt_wr_next   = 2'b00;
        w_valid_wr_next = 2'b00;
        if (w_word)
            w_pkt_wr_next[r_sel] = 1'b1;
        if (w_tail)
            w_valid_wr_next[r_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel     <= 1'b0;
            r_rr_ptr  <= 1'b0;
            r_exp     <= '0;
            r_cnt     <= '0;
            r_err_cnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_can_start) begin
                r_sel    <= w_pick;
                r_rr_ptr <= ~w_pick;
            end
            if (w_word) begin
                r_exp <= w_exp_now;
                r_cnt <= w_cnt_now;
            end
            if (w_tail && !w_match && (r_err_cnt != 16'hFFFF))
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic              r_pkt_wr;
        logic              r_valid_wr;
        logic              r_valid;
        logic [WORD_W-1:0] r_pkt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_pkt_wr   <= 1'b0;
                r_valid_wr <= 1'b0;
                r_valid    <= 1'b0;
                r_pkt      <= '0;
            end else begin
                r_pkt_wr   <= w_pkt_wr_next[gi];
                r_valid_wr <= w_valid_wr_next[gi];
                if (w_pkt_wr_next[gi])
                    r_pkt <= w_pkt_q;
                if (w_valid_wr_next[gi])
                    r_valid <= w_valid_bit;
            end
        end
    end

    assign out_pkt_wr_0   = g_port[0].r_pkt_wr;
    assign out_pkt_0      = g_port[0].r_pkt;
    assign out_valid_wr_0 = g_port[0].r_valid_wr;
    assign out_valid_0    = g_port[0].r_valid;
    assign out_pkt_wr_1   = g_port[1].r_pkt_wr;
    assign out_pkt_1      = g_port[1].r_pkt;
    assign out_valid_wr_1 = g_port[1].r_valid_wr;
    assign out_valid_1    = g_port[1].r_valid;
    assign err_cnt        = r_err_cnt;

endmodule
